// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes vs. buffered load returns.
// Two-entry load FIFO with live bits, starvation stall and collision flag.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_we,
   input  logic [4:0]  ex_waddr,
   input  logic [31:0] ex_wdata,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_waddr,
   input  logic [31:0] ld_wdata,
   output logic        rf_we,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic        stall_req,
   output logic [1:0]  ld_pending,
   output logic        err_collide
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef struct packed {
      logic        live;
      logic [4:0]  addr;
      logic [31:0] data;
   } ent_t;

   ent_t       s0_q, s1_q, s0_n, s1_n;
   ent_t       c0, c1, in_ent;
   logic [1:0] cnt_q, cnt_n;
   logic [3:0] starve_q, starve_n;
   logic       err_q;
   logic       ex_req, head_live, grant_ld, grant_ex;
   logic       pop, push;

   assign ld_pending  = cnt_q;
   assign ld_ready    = (cnt_q != 2'd2);
   assign stall_req   = (starve_q >= LIMIT);
   assign err_collide = err_q;

   // Grant decision, live-bit kill, FIFO shift/append and starve update.
   always_comb begin
      ex_req    = ex_we && (ex_waddr != 5'd0);
      head_live = (cnt_q != 2'd0) && s0_q.live;
      grant_ld  = head_live && (!ex_req || stall_req);
      grant_ex  = ex_req && !grant_ld;
      pop       = (cnt_q != 2'd0) && (!s0_q.live || grant_ld);
      push      = ld_valid && ld_ready && (ld_waddr != 5'd0);
      in_ent    = {1'b1, ld_waddr, ld_wdata};
      c0 = s0_q;
      c1 = s1_q;
      if (grant_ex) begin
         if (c0.addr == ex_waddr) c0.live = 1'b0;
         if (c1.addr == ex_waddr) c1.live = 1'b0;
      end
      s0_n  = c0;
      s1_n  = c1;
      cnt_n = cnt_q;
      if (pop) begin
         s0_n  = c1;
         cnt_n = cnt_q - 2'd1;
      end
      if (push) begin
         if (cnt_n == 2'd0) s0_n = in_ent;
         else               s1_n = in_ent;
         cnt_n = cnt_n + 2'd1;
      end
      if (head_live && !grant_ld)
         starve_n = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
      else
         starve_n = 4'd0;
   end

   // FIFO, starve counter and sticky error state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_q     <= '0;
         s1_q     <= '0;
         cnt_q    <= 2'd0;
         starve_q <= 4'd0;
         err_q    <= 1'b0;
      end else begin
         s0_q     <= s0_n;
         s1_q     <= s1_n;
         cnt_q    <= cnt_n;
         starve_q <= starve_n;
         if (ex_req && grant_ld) err_q <= 1'b1;
      end
   end

   // Registered register-file write port; address/data hold when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= 5'd0;
         rf_wdata <= 32'd0;
      end else if (grant_ex) begin
         rf_we    <= 1'b1;
         rf_waddr <= ex_waddr;
         rf_wdata <= ex_wdata;
      end else if (grant_ld) begin
         rf_we    <= 1'b1;
         rf_waddr <= s0_q.addr;
         rf_wdata <= s0_q.data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter.
// Expected values are hand-computed per cycle.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_we;
   logic [4:0]  ex_waddr;
   logic [31:0] ex_wdata;
   logic        ld_valid;
   logic        ld_ready;
   logic [4:0]  ld_waddr;
   logic [31:0] ld_wdata;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        stall_req;
   logic [1:0]  ld_pending;
   logic        err_collide;

   int n_vec = 0;
   int n_bad = 0;

   regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
      .ld_valid(ld_valid), .ld_ready(ld_ready),
      .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .stall_req(stall_req), .ld_pending(ld_pending),
      .err_collide(err_collide)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic we, input logic [4:0] a,
                     input logic [31:0] d);
      ex_we = we; ex_waddr = a; ex_wdata = d;
   endtask

   task automatic ld(input logic v, input logic [4:0] a,
                     input logic [31:0] d);
      ld_valid = v; ld_waddr = a; ld_wdata = d;
   endtask

   task automatic rf(input string tag, input logic we,
                     input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".we"}, 32'(rf_we), 32'(we));
      chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
      chk({tag, ".data"}, rf_wdata, d);
   endtask

   initial begin
      rst_n = 1'b0;
      ex(0, 0, 0);
      ld(0, 0, 0);
      #1;
      chk("rst.rf_we", 32'(rf_we), 0);
      chk("rst.pend", 32'(ld_pending), 0);
      chk("rst.ready", 32'(ld_ready), 1);
      chk("rst.stall", 32'(stall_req), 0);
      chk("rst.err", 32'(err_collide), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel.rf_we", 32'(rf_we), 0);

      // ex write lands next cycle
      ex(1, 5, 32'hDEADBEEF);
      tick();
      rf("ex5", 1, 5, 32'hDEADBEEF);
      ex(0, 0, 0);
      tick();
      rf("ex_idle", 0, 5, 32'hDEADBEEF);

      // single load, two-cycle latency
      chk("ld7.ready", 32'(ld_ready), 1);
      ld(1, 7, 32'h11);
      tick();
      ld(0, 0, 0);
      chk("ld7.pend1", 32'(ld_pending), 1);
      chk("ld7.we0", 32'(rf_we), 0);
      tick();
      rf("ld7", 1, 7, 32'h11);
      chk("ld7.pend0", 32'(ld_pending), 0);

      // load to x0 accepted but dropped
      ld(1, 0, 32'h55);
      tick();
      ld(0, 0, 0);
      chk("x0.pend", 32'(ld_pending), 0);
      tick();
      chk("x0.we", 32'(rf_we), 0);

      // fill FIFO under ex pressure, starve, then drain
      ex(1, 3, 32'hA);
      ld(1, 10, 32'hA0);
      tick();
      chk("st.pend1", 32'(ld_pending), 1);
      ld(1, 11, 32'hB0);
      tick();
      ld(0, 0, 0);
      chk("st.pend2", 32'(ld_pending), 2);
      chk("st.ready0", 32'(ld_ready), 0);
      chk("st.stall_e2", 32'(stall_req), 0);
      tick();
      chk("st.stall_e3", 32'(stall_req), 0);
      tick();
      chk("st.stall_e4", 32'(stall_req), 0);
      tick();
      chk("st.stall_e5", 32'(stall_req), 1);
      rf("st.exwin", 1, 3, 32'hA);
      ex(0, 0, 0);
      tick();
      rf("st.drain10", 1, 10, 32'hA0);
      chk("st.stall_clr", 32'(stall_req), 0);
      tick();
      rf("st.drain11", 1, 11, 32'hB0);
      chk("st.pend0", 32'(ld_pending), 0);
      chk("st.err", 32'(err_collide), 0);

      // ex write to same reg kills the stored load
      ex(1, 3, 32'h1);
      ld(1, 9, 32'h99);
      tick();
      ld(0, 0, 0);
      chk("kill.pend1", 32'(ld_pending), 1);
      ex(1, 9, 32'h900D);
      tick();
      rf("kill.ex9", 1, 9, 32'h900D);
      ex(0, 0, 0);
      tick();
      rf("kill.pop", 0, 9, 32'h900D);
      chk("kill.pend0", 32'(ld_pending), 0);

      // forced grant under stall with colliding ex write
      ex(1, 3, 32'h3);
      ld(1, 12, 32'hC0);
      tick();
      ld(0, 0, 0);
      repeat (3) tick();
      chk("col.stall0", 32'(stall_req), 0);
      tick();
      chk("col.stall1", 32'(stall_req), 1);
      ex(1, 4, 32'h4444);
      tick();
      rf("col.ldwin", 1, 12, 32'hC0);
      chk("col.err1", 32'(err_collide), 1);
      tick();
      rf("col.exnext", 1, 4, 32'h4444);
      ex(0, 0, 0);
      tick();
      chk("col.err_hold", 32'(err_collide), 1);
      chk("col.idle", 32'(rf_we), 0);

      // async reset with two entries pending
      ex(1, 3, 32'h7);
      ld(1, 20, 32'hE0);
      tick();
      ld(1, 21, 32'hE1);
      tick();
      ld(0, 0, 0);
      ex(0, 0, 0);
      chk("mrst.pend2", 32'(ld_pending), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mrst.pend", 32'(ld_pending), 0);
      chk("mrst.ready", 32'(ld_ready), 1);
      chk("mrst.we", 32'(rf_we), 0);
      chk("mrst.err", 32'(err_collide), 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mrst.nowr", 32'(rf_we), 0);
      end
      chk("mrst.pend_end", 32'(ld_pending), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
